// File: rtl/cam_pkg.sv
// Camera front-end shared types: sensor init table, sequencer and SCCB phase enums, RGB565 expansion.
// Latency: n/a, constants and types only.
// Backpressure: n/a.
package cam_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  val;
    } cam_init_entry_t;

    localparam int CAM_NUM_REGS = 16;

    // Soft reset, PLL/clock setup, then RGB565 output format last.
    localparam cam_init_entry_t CAM_INIT_TABLE [CAM_NUM_REGS] = '{
        '{16'h3008, 8'h82}, '{16'h3008, 8'h42}, '{16'h3103, 8'h03}, '{16'h3017, 8'hff},
        '{16'h3018, 8'hff}, '{16'h3034, 8'h1a}, '{16'h3037, 8'h13}, '{16'h3108, 8'h01},
        '{16'h3630, 8'h36}, '{16'h3631, 8'h0e}, '{16'h3632, 8'he2}, '{16'h3633, 8'h12},
        '{16'h3621, 8'he0}, '{16'h3704, 8'ha0}, '{16'h3703, 8'h5a}, '{16'h4300, 8'h61}
    };

    typedef enum logic [2:0] {
        ST_PWR_WAIT, ST_GAP, ST_WRITE, ST_NEXT, ST_DONE
    } cam_init_state_t;

    typedef enum logic [2:0] {
        PH_IDLE, PH_START, PH_BYTE, PH_ACK, PH_STOP
    } sccb_phase_t;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = p[15:11];
        g = p[10:5];
        b = p[4:0];
        return {b, b[4:2], g, g[5:4], r, r[4:2]};
    endfunction

endpackage

// File: rtl/cam_frontend_sccb_writer.sv
// One SCCB 3-phase write (START, 4 bytes with ACK slots, STOP); CAM_ACK_CHECK_EN aborts the frame on NACK.
// Latency: pins follow the internal phase by one cycle; done pulses as the STOP release is registered.
// Backpressure: start is accepted only while busy=0; no clock stretching.
module sccb_writer
    import cam_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = 8'h78,
    parameter int         SCL_Q    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  val,
    input  logic        sda_i,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic        scl_out_en,
    output logic        sda_out_en
);
    localparam int QW = (SCL_Q > 1) ? $clog2(SCL_Q) : 1;

    sccb_phase_t   phase;
    logic [1:0]    qtr;
    logic [QW-1:0] qcnt;
    logic [1:0]    byte_idx;
    logic [2:0]    bit_idx;
    logic [31:0]   frame;
    logic          q_end;
    logic          abort;
    logic          scl_nx;
    logic          sda_nx;

    assign q_end = (qcnt == QW'(SCL_Q - 1));

`ifdef CAM_ACK_CHECK_EN
    assign abort = nack;
`else
    assign abort = 1'b0;
`endif

    // Out-enable levels per phase/quarter; 1 pulls the line low.
    always_comb begin
        scl_nx = 1'b0;
        sda_nx = 1'b0;
        unique case (phase)
            PH_START: begin
                sda_nx = (qtr != 2'd0);
                scl_nx = (qtr == 2'd2);
            end
            PH_BYTE: begin
                sda_nx = ~frame[31];
                scl_nx = (qtr == 2'd0) || (qtr == 2'd3);
            end
            PH_ACK:  scl_nx = (qtr == 2'd0) || (qtr == 2'd3);
            PH_STOP: begin
                sda_nx = 1'b1;
                scl_nx = (qtr == 2'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= PH_IDLE;
            qtr        <= 2'd0;
            qcnt       <= '0;
            byte_idx   <= 2'd0;
            bit_idx    <= 3'd0;
            frame      <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
            scl_out_en <= 1'b0;
            sda_out_en <= 1'b0;
        end else begin
            scl_out_en <= scl_nx;
            sda_out_en <= sda_nx;
            done       <= 1'b0;
            if (phase == PH_IDLE) begin
                qtr  <= 2'd0;
                qcnt <= '0;
                if (start) begin
                    phase    <= PH_START;
                    frame    <= {DEV_ADDR, addr, val};
                    byte_idx <= 2'd0;
                    bit_idx  <= 3'd0;
                    nack     <= 1'b0;
                    busy     <= 1'b1;
                end
            end else begin
                qcnt <= q_end ? '0 : qcnt + 1'b1;
                // Mid-SCL-high sample of the ACK slot.
                if (phase == PH_ACK && qtr == 2'd1 && q_end)
                    nack <= nack | sda_i;
                if (q_end) begin
                    qtr <= qtr + 2'd1;
                    case (phase)
                        PH_START: if (qtr == 2'd2) begin
                            phase <= PH_BYTE;
                            qtr   <= 2'd0;
                        end
                        PH_BYTE: if (qtr == 2'd3) begin
                            frame   <= {frame[30:0], 1'b0};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                phase <= PH_ACK;
                        end
                        PH_ACK: if (qtr == 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            phase    <= (byte_idx == 2'd3 || abort) ? PH_STOP : PH_BYTE;
                        end
                        PH_STOP: if (qtr == 2'd1) begin
                            phase <= PH_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/cam_frontend.sv
// Sensor power-up, SCCB register-table sequencer and DVP byte-pair capture; CAM_ACK_CHECK_EN retries NACKed entries.
// Latency: de one cycle after the second byte; cam_init_done one cycle after the final STOP.
// Backpressure: none; pixels cannot be stalled, odd trailing bytes are dropped.
module cam_frontend
    import cam_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = 8'h78,
    parameter int         NUM_REGS = CAM_NUM_REGS,
    parameter int         SCL_Q    = 64,
    parameter int         PWR_DLY  = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        cmos_pwdn,
    output logic        cmos_rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        scl_o,
    output logic        sda_o,
    output logic        scl_out_en,
    output logic        sda_out_en,
    output logic        cam_init_done,
    output logic        vsync,
    output logic        de,
    output logic        half_cmos_clk,
    output logic [15:0] data_bgr565,
    output logic [23:0] data_bgr888
);
    localparam int CNT_MAX = (PWR_DLY > 4 * SCL_Q) ? PWR_DLY : 4 * SCL_Q;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    cam_init_state_t state;
    cam_init_entry_t entry;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            wr_start;
    logic            wr_busy;
    logic            wr_done;
    logic            wr_nack;
    logic            retry;
    logic            scl_unused;
    logic            armed;
    logic [7:0]      byte_a;

    assign scl_o      = 1'b0;
    assign sda_o      = 1'b0;
    assign scl_unused = scl_i;
    assign entry      = CAM_INIT_TABLE[idx];

`ifdef CAM_ACK_CHECK_EN
    assign retry = wr_nack;
`else
    logic nack_unused;
    assign retry       = 1'b0;
    assign nack_unused = wr_nack;
`endif

    sccb_writer #(
        .DEV_ADDR (DEV_ADDR),
        .SCL_Q    (SCL_Q)
    ) u_sccb (
        .clk        (clk),
        .rst        (rst),
        .start      (wr_start),
        .addr       (entry.addr),
        .val        (entry.val),
        .sda_i      (sda_i),
        .busy       (wr_busy),
        .done       (wr_done),
        .nack       (wr_nack),
        .scl_out_en (scl_out_en),
        .sda_out_en (sda_out_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_PWR_WAIT;
            cnt           <= '0;
            idx           <= '0;
            wr_start      <= 1'b0;
            cmos_pwdn     <= 1'b1;
            cmos_rst_n    <= 1'b0;
            cam_init_done <= 1'b0;
        end else begin
            wr_start <= 1'b0;
            case (state)
                ST_PWR_WAIT: begin
                    cmos_pwdn <= 1'b0;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(PWR_DLY / 2 - 1))
                        cmos_rst_n <= 1'b1;
                    if (cnt == CW'(PWR_DLY - 1)) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt == CW'(4 * SCL_Q - 1)) begin
                        if (!wr_busy) begin
                            cnt      <= '0;
                            wr_start <= 1'b1;
                            state    <= ST_WRITE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WRITE: if (wr_done) state <= retry ? ST_GAP : ST_NEXT;
                ST_NEXT: begin
                    if (idx == IW'(NUM_REGS - 1)) begin
                        cam_init_done <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_GAP;
                    end
                end
                ST_DONE: ;
                default: state <= ST_PWR_WAIT;
            endcase
        end
    end

    // Capture is armed by the first vsync rise after init so a partial frame never leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync         <= 1'b0;
            armed         <= 1'b0;
            half_cmos_clk <= 1'b0;
            de            <= 1'b0;
            byte_a        <= 8'd0;
            data_bgr565   <= 16'd0;
            data_bgr888   <= 24'd0;
        end else begin
            de <= 1'b0;
            if (cam_init_done) begin
                vsync <= cmos_vsync;
                if (cmos_vsync && !vsync)
                    armed <= 1'b1;
                if (!armed || cmos_vsync || !cmos_href) begin
                    half_cmos_clk <= 1'b0;
                end else if (!half_cmos_clk) begin
                    byte_a        <= cmos_data;
                    half_cmos_clk <= 1'b1;
                end else begin
                    data_bgr565   <= {byte_a, cmos_data};
                    data_bgr888   <= rgb565_to_888({byte_a, cmos_data});
                    de            <= 1'b1;
                    half_cmos_clk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_frontend.sv
// Directed bench for cam_frontend: power-up, SCCB frames via a slave model, init completion and pixel capture.
// Build with or without CAM_ACK_CHECK_EN; the slave NACKs the first address byte once.
module tb_cam_frontend;
    localparam int TB_SCL_Q   = 4;
    localparam int TB_PWR_DLY = 256;
    localparam int NREGS      = 16;
`ifdef CAM_ACK_CHECK_EN
    localparam int F0 = 1;
`else
    localparam int F0 = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmos_vsync, cmos_href;
    logic [7:0]  cmos_data;
    logic        cmos_pwdn, cmos_rst_n;
    logic        scl_i, sda_i, scl_o, sda_o, scl_out_en, sda_out_en;
    logic        cam_init_done, vsync, de, half_cmos_clk;
    logic [15:0] data_bgr565;
    logic [23:0] data_bgr888;

    int n_vec = 0;
    int n_err = 0;

    // Open-drain pads and SCCB slave model state.
    logic        scl_line, sda_line;
    logic        scl_q = 1'b1, sda_q = 1'b1, slave_low = 1'b0, in_frame = 1'b0;
    logic        nack_pending = 1'b1, done_q = 1'b0;
    logic [7:0]  shreg = 8'd0;
    logic [31:0] fdat = 32'd0;
    logic [31:0] log_dat [32];
    int          log_bits [32];
    int bitcnt = 0, nbytes = 0, nbits = 0, frames_seen = 0, bad_evt = 0;
    int since_stop = 0, done_lag = -1, de_cnt = 0, pre_de = 0, pre_vsync = 0;

    assign scl_line = ~scl_out_en;
    assign sda_line = ~(sda_out_en | slave_low);
    assign scl_i    = scl_line;
    assign sda_i    = sda_line;

    always #5 clk = ~clk;

    cam_frontend #(
        .SCL_Q   (TB_SCL_Q),
        .PWR_DLY (TB_PWR_DLY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmos_vsync    (cmos_vsync),
        .cmos_href     (cmos_href),
        .cmos_data     (cmos_data),
        .cmos_pwdn     (cmos_pwdn),
        .cmos_rst_n    (cmos_rst_n),
        .scl_i         (scl_i),
        .sda_i         (sda_i),
        .scl_o         (scl_o),
        .sda_o         (sda_o),
        .scl_out_en    (scl_out_en),
        .sda_out_en    (sda_out_en),
        .cam_init_done (cam_init_done),
        .vsync         (vsync),
        .de            (de),
        .half_cmos_clk (half_cmos_clk),
        .data_bgr565   (data_bgr565),
        .data_bgr888   (data_bgr888)
    );

    // The SCL rise inside STOP is counted as a rise, hence nbits-1 per logged frame.
    always @(negedge clk) begin
        scl_q      <= scl_line;
        sda_q      <= sda_line;
        done_q     <= cam_init_done;
        since_stop <= since_stop + 1;
        if (de) de_cnt <= de_cnt + 1;
        if (de && !cam_init_done) pre_de <= pre_de + 1;
        if (vsync && !cam_init_done) pre_vsync <= pre_vsync + 1;
        if (cam_init_done && !done_q) done_lag <= since_stop;
        if (scl_line && scl_q && sda_q && !sda_line) begin
            if (in_frame) bad_evt <= bad_evt + 1;
            in_frame <= 1'b1;
            bitcnt   <= 0;
            nbits    <= 0;
            nbytes   <= 0;
            fdat     <= 32'd0;
        end else if (scl_line && scl_q && !sda_q && sda_line) begin
            if (!in_frame) bad_evt <= bad_evt + 1;
            else if (frames_seen < 32) begin
                log_dat[frames_seen]  <= fdat;
                log_bits[frames_seen] <= nbits - 1;
            end
            in_frame    <= 1'b0;
            frames_seen <= frames_seen + 1;
            since_stop  <= 1;
        end else if (in_frame && scl_line && !scl_q) begin
            nbits <= nbits + 1;
            if (bitcnt < 8) begin
                shreg  <= {shreg[6:0], sda_line};
                bitcnt <= bitcnt + 1;
            end else begin
                fdat   <= {fdat[23:0], shreg};
                nbytes <= nbytes + 1;
                bitcnt <= 0;
            end
        end else if (in_frame && !scl_line && scl_q) begin
            if (bitcnt == 8) begin
                if (nack_pending && nbytes == 0) begin
                    slave_low    <= 1'b0;
                    nack_pending <= 1'b0;
                end else begin
                    slave_low <= 1'b1;
                end
            end else begin
                slave_low <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic h, input logic [7:0] d);
        cmos_href = h;
        cmos_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int oe_seen;
        rst        = 1'b1;
        cmos_vsync = 1'b0;
        cmos_href  = 1'b0;
        cmos_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pwdn",  32'(cmos_pwdn), 32'd1);
        chk("rst_rstn",  32'(cmos_rst_n), 32'd0);
        chk("rst_oe",    32'({scl_out_en, sda_out_en}), 32'd0);
        chk("rst_done",  32'(cam_init_done), 32'd0);
        chk("rst_flags", 32'({vsync, de, half_cmos_clk}), 32'd0);
        chk("rst_d565",  32'(data_bgr565), 32'd0);
        chk("rst_d888",  32'(data_bgr888), 32'd0);

        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("pwdn_rel", 32'(cmos_pwdn), 32'd0);
        repeat (TB_PWR_DLY / 2 - 2) @(posedge clk);
        #1;
        chk("rstn_early", 32'(cmos_rst_n), 32'd0);
        @(posedge clk);
        #1;
        chk("rstn_half", 32'(cmos_rst_n), 32'd1);

        // Pixel traffic before init must not get through.
        cmos_vsync = 1'b1;
        put(1'b0, 8'h00);
        cmos_vsync = 1'b0;
        put(1'b1, 8'hA1);
        put(1'b1, 8'hB2);
        put(1'b1, 8'hC3);
        put(1'b1, 8'hD4);
        put(1'b0, 8'h00);

        for (int i = 0; i < 40000; i++) begin
            if (cam_init_done) break;
            @(negedge clk);
        end
        #1;
        chk("init_done",   32'(cam_init_done), 32'd1);
        chk("pre_de",      32'(pre_de), 32'd0);
        chk("pre_vsync",   32'(pre_vsync), 32'd0);
        chk("frames",      32'(frames_seen), 32'(NREGS + F0));
        chk("bus_events",  32'(bad_evt), 32'd0);
        chk("done_lag",    32'(done_lag), 32'd1);
`ifdef CAM_ACK_CHECK_EN
        chk("nack_bits",   32'(log_bits[0]), 32'd9);
        chk("nack_byte",   log_dat[0], 32'h0000_0078);
`endif
        chk("f0_bytes",    log_dat[F0], 32'h7830_0882);
        chk("f0_bits",     32'(log_bits[F0]), 32'd36);
        chk("f1_bytes",    log_dat[F0 + 1], 32'h7830_0842);
        chk("flast_bytes", log_dat[F0 + NREGS - 1], 32'h7843_0061);

        oe_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (scl_out_en || sda_out_en) oe_seen++;
        end
        chk("bus_released", 32'(oe_seen), 32'd0);

        // Not yet armed: no vsync rise since init.
        base = de_cnt;
        put(1'b1, 8'h12);
        put(1'b1, 8'h34);
        put(1'b0, 8'h00);
        #1;
        chk("unarmed_de", 32'(de_cnt - base), 32'd0);

        cmos_vsync = 1'b1;
        put(1'b0, 8'h00);
        chk("vsync_out", 32'(vsync), 32'd1);
        cmos_vsync = 1'b0;
        put(1'b1, 8'hF8);
        chk("half_a", 32'({half_cmos_clk, de}), 32'b10);
        put(1'b1, 8'h00);
        chk("red_de",   32'({half_cmos_clk, de}), 32'b01);
        chk("red_565",  32'(data_bgr565), 32'h0000_F800);
        chk("red_888",  32'(data_bgr888), 32'h0000_00FF);
        put(1'b1, 8'h07);
        chk("grn_half", 32'({half_cmos_clk, de}), 32'b10);
        put(1'b1, 8'hE0);
        chk("grn_de",   32'(de), 32'd1);
        chk("grn_565",  32'(data_bgr565), 32'h0000_07E0);
        chk("grn_888",  32'(data_bgr888), 32'h0000_FF00);
        put(1'b0, 8'h00);
        chk("hold_de",  32'(de), 32'd0);
        chk("hold_565", 32'(data_bgr565), 32'h0000_07E0);

        base = de_cnt;
        put(1'b1, 8'h11);
        put(1'b1, 8'h22);
        put(1'b1, 8'h33);
        put(1'b0, 8'h00);
        put(1'b0, 8'h00);
        #1;
        chk("odd_de_cnt", 32'(de_cnt - base), 32'd1);
        chk("odd_half",   32'(half_cmos_clk), 32'd0);
        chk("odd_565",    32'(data_bgr565), 32'h0000_1122);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
